// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, per-frame config struct and parity helpers.
// Kept separate so a matching receiver can reuse the same frame description.
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  typedef struct packed {
    logic [3:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;
  } frame_cfg_t;

  // XOR of the first nbits data bits, inverted for odd parity.
  function automatic logic calc_parity(input logic [DATA_BITS_MAX-1:0] data,
                                       input logic [3:0]               nbits,
                                       input logic                     odd);
    logic p;
    p = odd;
    for (int i = 0; i < DATA_BITS_MAX; i++) begin
      if (4'(i) < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

  function automatic logic [3:0] norm_bits(input logic [3:0] nbits,
                                           input logic [3:0] max_bits);
    if (nbits < 4'(DATA_BITS_MIN) || nbits > max_bits) return max_bits;
    return nbits;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_bit_timer.sv
// Bit-period timer: counts enabled sample ticks and strobes bit_end on the last
// tick of each serial bit. Held at zero while clear is high.
module uart_bit_timer #(
  parameter int TICK_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic sample_tick,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (TICK_PER_BIT > 1) ? $clog2(TICK_PER_BIT) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_PER_BIT - 1);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (enable) begin
      if (clear) begin
        tick_cnt <= '0;
      end else if (sample_tick) begin
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      end
    end
  end

  assign bit_end = enable & sample_tick & ~clear & (tick_cnt == TICK_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Run-time configurable UART transmitter (5..DATA_W data bits, optional parity,
// 1 or 2 stop bits) with a one-word holding register for gapless back-to-back frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int TICK_PER_BIT = 16,
  parameter int DATA_W       = 9
) (
  input  logic              i_Clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              sample_tick,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [3:0]        i_data_bits,
  input  logic              i_parity_en,
  input  logic              i_parity_odd,
  input  logic              i_two_stop,
  output logic              o_TX,
  output logic              o_TX_Active,
  output logic              o_TX_Done
);

  localparam logic [3:0] MAX_BITS = 4'(DATA_W);

  uart_state_t state, state_n;
  logic        tx_n, active_n, done_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic        stop_cnt, stop_cnt_n;
  logic        load, shift, accept, bit_end;

  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  frame_cfg_t        hold_cfg;

  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic [3:0]        cur_bits;
  logic              cur_par_en, cur_two_stop;

  assign o_ready = ~hold_full;
  assign accept  = i_valid & ~hold_full & i_enable;

  uart_bit_timer #(
    .TICK_PER_BIT(TICK_PER_BIT)
  ) u_bit_timer (
    .clk        (i_Clock),
    .rst        (i_reset),
    .enable     (i_enable),
    .sample_tick(sample_tick),
    .clear      (state == IDLE),
    .bit_end    (bit_end)
  );

  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      o_TX         <= 1'b1;
      o_TX_Active  <= 1'b0;
      o_TX_Done    <= 1'b0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      hold_full    <= 1'b0;
      cur_bits     <= '0;
      cur_par_en   <= 1'b0;
      cur_two_stop <= 1'b0;
    end else if (i_enable) begin
      state       <= state_n;
      o_TX        <= tx_n;
      o_TX_Active <= active_n;
      o_TX_Done   <= done_n;
      bit_cnt     <= bit_cnt_n;
      stop_cnt    <= stop_cnt_n;
      if (accept)    hold_full <= 1'b1;
      else if (load) hold_full <= 1'b0;
      if (load) begin
        cur_bits     <= hold_cfg.data_bits;
        cur_par_en   <= hold_cfg.parity_en;
        cur_two_stop <= hold_cfg.two_stop;
      end
    end else begin
      o_TX_Done <= 1'b0;
    end
  end

  // Datapath words carry no reset: hold_full/state qualify every use.
  always_ff @(posedge i_Clock) begin
    if (i_enable) begin
      if (accept) begin
        hold_data <= i_data;
        hold_cfg  <= '{data_bits:  norm_bits(i_data_bits, MAX_BITS),
                       parity_en:  i_parity_en,
                       parity_odd: i_parity_odd,
                       two_stop:   i_two_stop};
      end
      if (load) begin
        shreg   <= hold_data;
        par_bit <= calc_parity(DATA_BITS_MAX'(hold_data), hold_cfg.data_bits,
                               hold_cfg.parity_odd);
      end else if (shift) begin
        shreg <= shreg >> 1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    tx_n       = o_TX;
    active_n   = o_TX_Active;
    done_n     = 1'b0;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        tx_n     = 1'b1;
        active_n = 1'b0;
        if (hold_full) begin
          load     = 1'b1;
          state_n  = START;
          tx_n     = 1'b0;
          active_n = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          tx_n      = shreg[0];
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == cur_bits - 4'd1) begin
            if (cur_par_en) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n    = STOP;
              tx_n       = 1'b1;
              stop_cnt_n = 1'b0;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
            shift     = 1'b1;
            tx_n      = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n    = STOP;
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (cur_two_stop && !stop_cnt) begin
            stop_cnt_n = 1'b1;
          end else begin
            done_n = 1'b1;
            // A waiting word starts on this same edge, so no idle gap appears.
            if (hold_full) begin
              load     = 1'b1;
              state_n  = START;
              tx_n     = 1'b0;
              active_n = 1'b1;
            end else begin
              state_n  = IDLE;
              tx_n     = 1'b1;
              active_n = 1'b0;
            end
          end
        end
      end
      default: begin
        state_n  = IDLE;
        tx_n     = 1'b1;
        active_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues hand-computed serial frames,
// a negedge monitor follows the line bit by bit and checks each frame's shape.
module tb_uart_tx_cfg;

  localparam int TPB = 4;
  localparam int DW  = 9;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b1;
  logic          tick  = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] data  = '0;
  logic [3:0]    nbits = 4'd8;
  logic          pen   = 1'b0;
  logic          podd  = 1'b0;
  logic          two   = 1'b0;
  logic          ready, tx, active, done;

  int n_checks = 0;
  int n_errors = 0;
  int exp_done = 0;
  int done_seen = 0;

  typedef struct {
    logic [15:0] seq;     // transmission order, first bit at the MSB end of len
    int          len;
    int          cycles;
    bit          b2b;
  } frame_t;

  frame_t sb[$];
  frame_t cur;
  bit     in_frame = 0;
  bit     frame_ok;
  bit     prev_tick = 0;
  int     t, cyc;

  always #5 clk = ~clk;

  uart_tx_cfg #(.TICK_PER_BIT(TPB), .DATA_W(DW)) dut (
    .i_Clock     (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .sample_tick (tick),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_data      (data),
    .i_data_bits (nbits),
    .i_parity_en (pen),
    .i_parity_odd(podd),
    .i_two_stop  (two),
    .o_TX        (tx),
    .o_TX_Active (active),
    .o_TX_Done   (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: t counts enabled ticks since the start edge, so disabled cycles stretch the bit.
  always @(negedge clk) begin
    if (rst) begin
      in_frame  = 0;
      sb.delete();
    end else begin
      if (done) done_seen++;
      if (in_frame) begin
        t   = t + int'(prev_tick);
        cyc = cyc + 1;
        if (t == cur.len * TPB) begin
          check("frame_bits", frame_ok, 1);
          check("frame_cycles", cyc, cur.cycles);
          check("done_at_end", done, 1);
          check("tail_tx", tx, cur.b2b ? 0 : 1);
          check("tail_active", active, cur.b2b ? 1 : 0);
          in_frame = 0;
        end else if (tx !== cur.seq[cur.len - 1 - t / TPB]) begin
          frame_ok = 0;
        end
      end
      if (!in_frame && tx == 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_start", sb.size(), 1);
        end else begin
          cur      = sb.pop_front();
          in_frame = 1;
          frame_ok = 1;
          t        = 0;
          cyc      = 0;
        end
      end
    end
    prev_tick = en & tick;
  end

  // kind: 0 normal, 1 aborted by reset (no done), 2 word expected to be discarded
  task automatic send(input logic [DW-1:0] d, input logic [3:0] nb, input logic pe,
                      input logic po, input logic ts, input logic [15:0] seq,
                      input int len, input int extra, input bit b2b, input int kind);
    frame_t f;
    int k;
    f.seq = seq; f.len = len; f.cycles = len * TPB + extra; f.b2b = b2b;
    if (kind != 2) sb.push_back(f);
    if (kind == 0) exp_done++;
    data = d; nbits = nb; pen = pe; podd = po; two = ts; valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (ready && en) break;
      k++;
      if (k > 2000) begin
        check("accept_timeout", k, 0);
        break;
      end
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (!in_frame && sb.size() == 0 && !active && ready) break;
      k++;
      if (k > 3000) begin
        check("idle_timeout", k, 0);
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_tx", tx, 1);
    check("rst_ready", ready, 1);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    #5 rst = 1'b0;
    @(posedge clk); #1;

    // 8N1 0x0A5
    send(9'h0A5, 4'd8, 0, 0, 0, 16'b0101001011, 10, 0, 0, 0);
    wait_idle();
    // 7E2 0x41, upper data bits set but ignored
    send(9'h1C1, 4'd7, 1, 0, 1, 16'b01000001011, 11, 0, 0, 0);
    wait_idle();
    // 8O1 0x00 -> parity 1
    send(9'h000, 4'd8, 1, 1, 0, 16'b00000000011, 11, 0, 0, 0);
    wait_idle();
    // data_bits=12 out of range -> 9 bits
    send(9'h155, 4'd12, 0, 0, 0, 16'b01010101011, 11, 0, 0, 0);
    wait_idle();
    // 5E1 minimum width, low bits 10011 -> parity 1
    send(9'h1F3, 4'd5, 1, 0, 0, 16'b01100111, 8, 0, 0, 0);
    wait_idle();

    // back-to-back 0x55 then 0xAA
    send(9'h055, 4'd8, 0, 0, 0, 16'b0101010101, 10, 0, 1, 0);
    check("hold_full_after_accept", ready, 0);
    @(posedge clk); #1;
    check("ready_after_load", ready, 1);
    send(9'h0AA, 4'd8, 0, 0, 0, 16'b0010101011, 10, 0, 0, 0);
    wait_idle();

    // enable low for 10 cycles inside data bit 1 of 0x0F
    send(9'h00F, 4'd8, 0, 0, 0, 16'b0111100001, 10, 10, 0, 0);
    repeat (10) @(posedge clk);
    #1 en = 1'b0;
    repeat (10) @(posedge clk);
    #1 en = 1'b1;
    wait_idle();

    // reset during a data bit with a second word held
    send(9'h033, 4'd8, 0, 0, 0, 16'b0110011001, 10, 0, 0, 1);
    send(9'h044, 4'd8, 0, 0, 0, 16'b0, 10, 0, 0, 2);
    repeat (12) @(posedge clk);
    #1;
    check("ready_before_reset", ready, 0);
    #1 rst = 1'b1;
    #1;
    check("abort_tx", tx, 1);
    check("abort_ready", ready, 1);
    check("abort_active", active, 0);
    check("abort_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send(9'h03C, 4'd8, 0, 0, 0, 16'b0001111001, 10, 0, 0, 0);
    wait_idle();

    check("done_count", done_seen, exp_done);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
